// File: rtl/chip8_alu_sequencer_if.sv
// rtl/chip8_alu_sequencer_if.sv - ALU function type and sequencer bus interface
//
// chip8_alu_pkg: ALU function select encoding shared by the sequencer, the ALU
// and anything that observes the ALU select lines.
//
// chip8_alu_sequencer_if groups every non-clock/reset signal of the sequencer:
//   op_valid/op_ready/opcode  upstream opcode handshake (decoder -> sequencer)
//   op_done/op_err            completion pulses back to the decoder
//   reg_addr/reg_rdata        register-file read port (synchronous read)
//   reg_we/reg_wdata          register-file write port (shares reg_addr)
//   alu_sel/alu_in1/alu_in2   combinational ALU controls and operands
//   alu_out                   combinational ALU result
// modport master: the sequencer side. modport slave: decoder/datapath side.

package chip8_alu_pkg;
  typedef enum logic [2:0] {
    ALU_f_NOP    = 3'd0,
    ALU_f_OR     = 3'd1,
    ALU_f_AND    = 3'd2,
    ALU_f_XOR    = 3'd3,
    ALU_f_ADD    = 3'd4,
    ALU_f_MINUS  = 3'd5,
    ALU_f_LSHIFT = 3'd6,
    ALU_f_RSHIFT = 3'd7
  } ALU_f;
endpackage

interface chip8_alu_sequencer_if;
  import chip8_alu_pkg::*;

  logic        op_valid;
  logic        op_ready;
  logic [15:0] opcode;
  logic        op_done;
  logic        op_err;
  logic [3:0]  reg_addr;
  logic [7:0]  reg_rdata;
  logic        reg_we;
  logic [7:0]  reg_wdata;
  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  ALU_f        alu_sel;
  logic [15:0] alu_out;

  modport master (
    input  op_valid, opcode, reg_rdata, alu_out,
    output op_ready, op_done, op_err, reg_addr, reg_we, reg_wdata,
           alu_in1, alu_in2, alu_sel
  );

  modport slave (
    output op_valid, opcode, reg_rdata, alu_out,
    input  op_ready, op_done, op_err, reg_addr, reg_we, reg_wdata,
           alu_in1, alu_in2, alu_sel
  );
endinterface

// File: rtl/chip8_alu_sequencer.sv
// rtl/chip8_alu_sequencer.sv - Chip-8 8XYn arithmetic/logic opcode sequencer
//
// Accepts one 8XYn opcode, reads Vx then Vy from the register file, drives
// the external combinational ALU for one cycle, writes the result to Vx and,
// for flag-producing opcodes, the flag to VF.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset, returns the block to IDLE
//   bus    chip8_alu_sequencer_if.master (opcode handshake, register-file
//          read/write port, ALU select/operands/result)

module chip8_alu_sequencer
  import chip8_alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  chip8_alu_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, RD_X, RD_Y, LAT, EXEC, WR_X, WR_F, ERR
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  x_q, y_q, n_q;
  logic [7:0]  vx_q, vy_q, res_q;
  logic        flag_q, flag_d;
  logic        ready, accept, legal;
  logic        unused_alu_hi;

  // op_ready drops the instant reset rises, not just after the next edge.
  assign ready  = (state_q == IDLE) && !reset;
  assign accept = bus.op_valid && ready;

  // Legal n values are 0..7 and E.
  assign legal = (bus.opcode[15:12] == 4'h8) &&
                 ((bus.opcode[3] == 1'b0) || (bus.opcode[3:0] == 4'hE));

  // Only bits [8:0] of the zero-extended ALU result carry information.
  assign unused_alu_hi = ^bus.alu_out[15:9];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = legal ? RD_X : ERR;
      RD_X:    state_d = RD_Y;
      RD_Y:    state_d = LAT;
      LAT:     state_d = EXEC;
      EXEC:    state_d = WR_X;
      WR_X:    state_d = (n_q[3:2] == 2'b00) ? IDLE : WR_F;
      WR_F:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand, result and flag latches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q    <= '0;
      y_q    <= '0;
      n_q    <= '0;
      vx_q   <= '0;
      vy_q   <= '0;
      res_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      if (accept) begin
        x_q <= bus.opcode[11:8];
        y_q <= bus.opcode[7:4];
        n_q <= bus.opcode[3:0];
      end
      // Read data lags the address by one cycle: Vx arrives in RD_Y, Vy in LAT.
      if (state_q == RD_Y) vx_q <= bus.reg_rdata;
      if (state_q == LAT)  vy_q <= bus.reg_rdata;
      if (state_q == EXEC) begin
        res_q  <= bus.alu_out[7:0];
        flag_q <= flag_d;
      end
    end
  end

  // Flag from the EXEC-cycle ALU result. Subtraction of zero-extended
  // operands sets bit 8 on borrow, so "no borrow" is its inverse.
  always_comb begin
    flag_d = 1'b0;
    case (n_q)
      4'h4, 4'hE: flag_d = bus.alu_out[8];
      4'h5, 4'h7: flag_d = ~bus.alu_out[8];
      4'h6:       flag_d = vx_q[0];
      default:    flag_d = 1'b0;
    endcase
  end

  // Outputs
  always_comb begin
    bus.op_ready  = ready;
    bus.op_done   = 1'b0;
    bus.op_err    = 1'b0;
    bus.reg_addr  = 4'h0;
    bus.reg_we    = 1'b0;
    bus.reg_wdata = 8'h00;
    bus.alu_sel   = ALU_f_NOP;
    bus.alu_in1   = 16'h0000;
    bus.alu_in2   = 16'h0000;
    case (state_q)
      RD_X: bus.reg_addr = x_q;
      RD_Y: bus.reg_addr = y_q;
      EXEC: begin
        case (n_q)
          4'h0: begin
            bus.alu_sel = ALU_f_OR;
            bus.alu_in2 = {8'h00, vy_q};
          end
          4'h1: begin
            bus.alu_sel = ALU_f_OR;
            bus.alu_in1 = {8'h00, vx_q};
            bus.alu_in2 = {8'h00, vy_q};
          end
          4'h2: begin
            bus.alu_sel = ALU_f_AND;
            bus.alu_in1 = {8'h00, vx_q};
            bus.alu_in2 = {8'h00, vy_q};
          end
          4'h3: begin
            bus.alu_sel = ALU_f_XOR;
            bus.alu_in1 = {8'h00, vx_q};
            bus.alu_in2 = {8'h00, vy_q};
          end
          4'h4: begin
            bus.alu_sel = ALU_f_ADD;
            bus.alu_in1 = {8'h00, vx_q};
            bus.alu_in2 = {8'h00, vy_q};
          end
          4'h5: begin
            bus.alu_sel = ALU_f_MINUS;
            bus.alu_in1 = {8'h00, vx_q};
            bus.alu_in2 = {8'h00, vy_q};
          end
          4'h7: begin
            bus.alu_sel = ALU_f_MINUS;
            bus.alu_in1 = {8'h00, vy_q};
            bus.alu_in2 = {8'h00, vx_q};
          end
          4'h6: begin
            bus.alu_sel = ALU_f_RSHIFT;
            bus.alu_in1 = {8'h00, vx_q};
            bus.alu_in2 = 16'h0001;
          end
          4'hE: begin
            bus.alu_sel = ALU_f_LSHIFT;
            bus.alu_in1 = {8'h00, vx_q};
            bus.alu_in2 = 16'h0001;
          end
          default: bus.alu_sel = ALU_f_NOP;
        endcase
      end
      WR_X: begin
        bus.reg_we    = 1'b1;
        bus.reg_addr  = x_q;
        bus.reg_wdata = res_q;
        bus.op_done   = (n_q[3:2] == 2'b00);
      end
      WR_F: begin
        // When X is F this overwrites the WR_X result, so the flag wins.
        bus.reg_we    = 1'b1;
        bus.reg_addr  = 4'hF;
        bus.reg_wdata = {7'b0, flag_q};
        bus.op_done   = 1'b1;
      end
      ERR: bus.op_err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_chip8_alu_sequencer.sv
// tb/tb_chip8_alu_sequencer.sv - self-checking bench for chip8_alu_sequencer

module tb_chip8_alu_sequencer;
  import chip8_alu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  chip8_alu_sequencer_if bus();

  chip8_alu_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] regs [16];
  logic [7:0] exp_regs [16];
  logic       pl_en = 1'b0;
  logic [3:0] pl_addr = 4'h0;
  logic [7:0] pl_data = 8'h00;

  int n_checks = 0;
  int n_fail = 0;

  // Register file: synchronous read, write on reg_we, bench backdoor preload.
  always @(posedge clk) begin
    if (pl_en)           regs[pl_addr] <= pl_data;
    else if (bus.reg_we) regs[bus.reg_addr] <= bus.reg_wdata;
    bus.reg_rdata <= regs[bus.reg_addr];
  end

  // Combinational ALU on zero-extended 16-bit operands.
  always_comb begin
    case (bus.alu_sel)
      ALU_f_OR:     bus.alu_out = bus.alu_in1 | bus.alu_in2;
      ALU_f_AND:    bus.alu_out = bus.alu_in1 & bus.alu_in2;
      ALU_f_XOR:    bus.alu_out = bus.alu_in1 ^ bus.alu_in2;
      ALU_f_ADD:    bus.alu_out = bus.alu_in1 + bus.alu_in2;
      ALU_f_MINUS:  bus.alu_out = bus.alu_in1 - bus.alu_in2;
      ALU_f_LSHIFT: bus.alu_out = bus.alu_in1 << bus.alu_in2;
      ALU_f_RSHIFT: bus.alu_out = bus.alu_in1 >> bus.alu_in2;
      default:      bus.alu_out = 16'h0000;
    endcase
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Chip-8 semantics of 8XYn: returns {VF flag, new Vx}.
  function automatic logic [8:0] ref_op(input logic [3:0] n, input logic [7:0] x, input logic [7:0] y);
    int s;
    case (n)
      4'h0: return {1'b0, y};
      4'h1: return {1'b0, x | y};
      4'h2: return {1'b0, x & y};
      4'h3: return {1'b0, x ^ y};
      4'h4: begin s = int'(x) + int'(y); return {s > 255, s[7:0]}; end
      4'h5: begin s = int'(x) - int'(y); return {x >= y, s[7:0]}; end
      4'h7: begin s = int'(y) - int'(x); return {y >= x, s[7:0]}; end
      4'h6: return {x[0], x >> 1};
      4'hE: return {x[7], 8'(x << 1)};
      default: return 9'h000;
    endcase
  endfunction

  task automatic preload(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
    exp_regs[a] = d;
  endtask

  task automatic run_op(input logic [15:0] op);
    logic [3:0] x, y, n;
    logic       legal;
    logic [8:0] r;
    int         last;
    x = op[11:8]; y = op[7:4]; n = op[3:0];
    legal = (op[15:12] == 4'h8) && (n <= 4'h7 || n == 4'hE);
    r = ref_op(n, exp_regs[x], exp_regs[y]);
    last = (n <= 4'h3) ? 5 : 6;
    @(negedge clk);
    bus.opcode = op; bus.op_valid = 1'b1;
    check($sformatf("%h ready_c0", op), bus.op_ready, 1);
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    bus.opcode = 16'($urandom);
    for (int c = 1; c <= 7; c++) begin
      logic exp_we, exp_done, exp_ready;
      @(negedge clk);
      exp_we    = legal && (c == 5 || (c == 6 && last == 6));
      exp_done  = legal && (c == last);
      exp_ready = legal ? (c > last) : (c >= 2);
      check($sformatf("%h done_c%0d", op, c), bus.op_done, exp_done);
      check($sformatf("%h err_c%0d", op, c), bus.op_err, !legal && c == 1);
      check($sformatf("%h ready_c%0d", op, c), bus.op_ready, exp_ready);
      check($sformatf("%h we_c%0d", op, c), bus.reg_we, exp_we);
      if (exp_we) begin
        check($sformatf("%h waddr_c%0d", op, c), bus.reg_addr, (c == 5) ? x : 4'hF);
        check($sformatf("%h wdata_c%0d", op, c), bus.reg_wdata, (c == 5) ? r[7:0] : {7'b0, r[8]});
      end
      if (!(legal && c == 4))
        check($sformatf("%h alu_nop_c%0d", op, c), bus.alu_sel, ALU_f_NOP);
    end
    if (legal) begin
      exp_regs[x] = r[7:0];
      if (last == 6) exp_regs[15] = {7'b0, r[8]};
    end
    check($sformatf("%h vx_final", op), regs[x], exp_regs[x]);
    check($sformatf("%h vf_final", op), regs[15], exp_regs[15]);
  endtask

  task automatic reset_mid_exec();
    preload(4'h3, 8'hF0);
    preload(4'h4, 8'h20);
    @(negedge clk);
    bus.opcode = 16'h8344; bus.op_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_ready", bus.op_ready, 0);
    check("rst_we", bus.reg_we, 0);
    check("rst_alu_sel", bus.alu_sel, ALU_f_NOP);
    check("rst_alu_in1", bus.alu_in1, 0);
    check("rst_done", bus.op_done, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_hold_we_%0d", i), bus.reg_we, 0);
      check($sformatf("rst_hold_ready_%0d", i), bus.op_ready, 0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("rst_release_ready", bus.op_ready, 1);
    check("rst_release_we", bus.reg_we, 0);
    check("rst_v3_kept", regs[3], exp_regs[3]);
    check("rst_vf_kept", regs[15], exp_regs[15]);
  endtask

  initial begin
    bus.op_valid = 1'b0;
    bus.opcode   = 16'h0000;

    #3;
    check("reset_ready", bus.op_ready, 0);
    check("reset_done", bus.op_done, 0);
    check("reset_err", bus.op_err, 0);
    check("reset_we", bus.reg_we, 0);
    check("reset_addr", bus.reg_addr, 0);
    check("reset_wdata", bus.reg_wdata, 0);
    check("reset_alu_sel", bus.alu_sel, ALU_f_NOP);
    check("reset_alu_in1", bus.alu_in1, 0);
    check("reset_alu_in2", bus.alu_in2, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) preload(4'(i), 8'h00);

    preload(4'h3, 8'hF0); preload(4'h4, 8'h20);
    run_op(16'h8344);
    preload(4'h1, 8'h05); preload(4'h2, 8'h07);
    run_op(16'h8125);
    preload(4'h1, 8'h07);
    run_op(16'h8125);
    preload(4'h6, 8'h81);
    run_op(16'h860E);
    preload(4'h6, 8'h03);
    run_op(16'h8606);
    preload(4'hF, 8'h01); preload(4'h1, 8'h01);
    run_op(16'h8F14);
    run_op(16'h8128);
    run_op(16'h9120);
    preload(4'hA, 8'h0C); preload(4'h3, 8'h30);
    run_op(16'h8A31);

    reset_mid_exec();
    run_op(16'h8344);

    for (int k = 0; k < 40; k++) begin
      logic [15:0] op;
      op = {4'h8, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      if ($urandom_range(0, 7) == 0) op = 16'($urandom);
      preload(op[11:8], 8'($urandom));
      preload(op[7:4], 8'($urandom));
      run_op(op);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chip8_alu_sequencer.md
# chip8_alu_sequencer

Executes Chip-8 arithmetic/logic opcodes (8XYn) by sequencing register-file reads, driving the combinational Chip8 ALU, and writing the result back to Vx and the flag to VF. It sits between the instruction decoder and the datapath.
- Upstream: it accepts one opcode at a time over a valid/ready handshake.
- Downstream: it is the sole driver of the ALU select and operand inputs while busy.

## Interface
- `clk`  in  1  system clock; all state on rising edge
- `reset`  in  1  asynchronous, active-high; returns block to IDLE
- `op_valid`  in  1  opcode offered
- `op_ready`  out  1  high only in IDLE and reset deasserted
- `opcode`  in  16  8XYn word; sampled on accept (`op_valid & op_ready`)
- `op_done`  out  1  one-cycle pulse, last write cycle of a legal opcode
- `op_err`  out  1  one-cycle pulse for illegal opcode
- `reg_addr`  out  4  register-file address
- `reg_rdata`  in  8  read data, valid one cycle after `reg_addr` (synchronous read)
- `reg_we`  out  1  register-file write enable
- `reg_wdata`  out  8  write data
- `alu_in1`, `alu_in2`  out  16  ALU operands, zero-extended 8-bit values
- `alu_sel`  out  ALU_f  ALU function select; ALU_f_NOP when not in EXEC
- `alu_out`  in  16  combinational ALU result

## Operation
- States: IDLE, RD_X, RD_Y, LAT, EXEC, WR_X, WR_F, ERR.
- IDLE: on accept, latch X = `opcode[11:8]`, Y = `opcode[7:4]`, n = `opcode[3:0]`.
  - `opcode[15:12]` ≠ 8, or n ∉ {0,1,2,3,4,5,6,7,E} → ERR.
  - Otherwise → RD_X.
- RD_X: `reg_addr`=X → RD_Y.
- RD_Y: `reg_addr`=Y; latch `vx_q`=`reg_rdata` → LAT.
- LAT: latch `vy_q`=`reg_rdata` → EXEC. Both registers are always read, so latency is fixed.
- EXEC: drive the ALU and latch `res_q`=`alu_out` → WR_X. Operation by n:
  - 0: OR, in1=0, in2=Vy
  - 1: OR, in1=Vx, in2=Vy
  - 2: AND, in1=Vx, in2=Vy
  - 3: XOR, in1=Vx, in2=Vy
  - 4: ADD, in1=Vx, in2=Vy; flag=`alu_out[8]`
  - 5: MINUS, in1=Vx, in2=Vy; flag=~`alu_out[8]` (1 when Vx ≥ Vy)
  - 7: MINUS, in1=Vy, in2=Vx; flag=~`alu_out[8]`
  - 6: RSHIFT, in1=Vx, in2=1; flag=Vx[0]
  - E: LSHIFT, in1=Vx, in2=1; flag=`alu_out[8]`
- WR_X: `reg_we`=1, `reg_addr`=X, `reg_wdata`=`res_q[7:0]`.
  - n ∈ {0..3}: pulse `op_done` → IDLE. VF is untouched.
  - Otherwise → WR_F.
- WR_F: `reg_we`=1, `reg_addr`=F, `reg_wdata`={7'b0, flag}; pulse `op_done` → IDLE.
- ERR: pulse `op_err`, no writes → IDLE.
- X=F: VF is written in WR_X and then overwritten in WR_F, so the flag wins.
- X=Y: both reads return the same value. Legal.
- The ALU `alu_carry` output is not used. All flags derive from bit 8 of the zero-extended result.

## Timing
- Reset values: state IDLE, `op_ready`=0 while `reset` is high, `op_done`=0, `op_err`=0, `reg_we`=0, `reg_addr`=0, `reg_wdata`=0, `alu_sel`=ALU_f_NOP, `alu_in1`=`alu_in2`=0, internal latches 0.
- Accept cycle is c0. RD_X c1, RD_Y c2, LAT c3, EXEC c4, WR_X c5.
  - n ∈ {0..3}: `op_done` at c5; `op_ready` high again c6.
  - Otherwise: WR_F and `op_done` at c6; `op_ready` high again c7.
- Illegal opcode: `op_err` at c1; `op_ready` high c2.
- `op_valid` while busy is ignored, since `op_ready`=0. The opcode must be held until accepted.
- At most one `reg_we` per cycle. `reg_we` is never high outside WR_X/WR_F.
- Reset mid-operation: all outputs take reset values immediately (asynchronous). No further writes occur. A write already completed in WR_X stands; pending WR_F is dropped.

## Test plan
- 8344 with V3=0xF0, V4=0x20 → c5 write V3=0x10; c6 write VF=0x01, `op_done` at c6.
- 8125 with V1=0x05, V2=0x07 → V1=0xFE, VF=0x00. Repeat with V1=0x07, V2=0x07 → V1=0x00, VF=0x01.
- 860E with V6=0x81 → V6=0x02, VF=0x01. Then 8606 with V6=0x03 → V6=0x01, VF=0x01.
- 8F14 with VF=0x01, V1=0x01 → WR_X writes VF=0x02, then WR_F writes VF=0x00. Final VF=0x00.
- 8128 and 9120 → `op_err` pulse at c1, zero `reg_we` cycles, `op_ready` back at c2. Then 8A31 (VA=0x0C, V3=0x30) → VA=0x3C, `op_done` at c5, no VF write.
- Assert `reset` during EXEC of 8344 → `reg_we` never asserts, `op_ready` low during reset, high the cycle after release. A following 8344 completes normally.
